// File: rtl/mul_booth_pipe_if.sv
// Handshake bundle for mul_booth_pipe.
// Issue side: Flush, InValid/InReady, MulOp, Multiplicand, Multiplier, InTag.
// Result side: OutValid/OutReady, ProductData, OutTag.
// master: the issue stage and result consumer; slave: the multiplier.
interface mul_booth_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic             Flush;
  logic             InValid;
  logic             InReady;
  logic [1:0]       MulOp;
  logic [WIDTH-1:0] Multiplicand;
  logic [WIDTH-1:0] Multiplier;
  logic [TAG_W-1:0] InTag;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] ProductData;
  logic [TAG_W-1:0] OutTag;

  modport master (
    output Flush, InValid, MulOp, Multiplicand, Multiplier, InTag, OutReady,
    input  InReady, OutValid, ProductData, OutTag
  );

  modport slave (
    input  Flush, InValid, MulOp, Multiplicand, Multiplier, InTag, OutReady,
    output InReady, OutValid, ProductData, OutTag
  );
endinterface

// File: rtl/mul_booth_pipe.sv
// Three-stage radix-4 Booth / carry-save multiplier (MUL, MULH, MULHU).
// Ports:
//   Clk  - rising-edge clock
//   Rest - asynchronous active-low reset
//   bus  - mul_booth_pipe_if.slave: operands, op, tag, flush, result handshake
// S1 recodes the multiplier and registers the partial products, S2 reduces them
// with a 3:2 carry-save tree, S3 does the final add and word select.
// The whole pipe advances only when the output slot is empty or being taken.
module mul_booth_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic             Clk,
  input logic             Rest,
  mul_booth_pipe_if.slave bus
);
  localparam int Ew      = WIDTH + 2;
  localparam int NumPp   = Ew / 2;
  // Rows are kept to 2*WIDTH bits: higher columns never reach either selected word.
  localparam int Pw      = 2 * WIDTH;
  localparam int NumRows = NumPp + 1;

  logic             adv;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             s1_valid_q, s2_valid_q;
  logic [1:0]       s1_op_q, s2_op_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic [Pw-1:0]    s1_pp_q [NumPp];
  logic [Pw-1:0]    s1_corr_q;
  logic [Pw-1:0]    s2_sum_q, s2_carry_q;

  assign adv              = ~out_valid_q | bus.OutReady;
  assign bus.InReady      = adv;
  assign bus.OutValid     = out_valid_q;
  assign bus.ProductData  = out_data_q;
  assign bus.OutTag       = out_tag_q;

  // S1: operand extension and Booth recoding.
  logic            signed_op;
  logic [Ew-1:0]   a_ext, b_ext;
  logic [Ew:0]     b_app;
  logic [Pw-1:0]   a_pw;
  logic [Pw-1:0]   pp_d [NumPp];
  logic [Pw-1:0]   corr_d;
  logic [2:0]      dig;
  logic [Pw-1:0]   mag;
  logic            neg;

  always_comb begin
    signed_op = (bus.MulOp != 2'b10);
    a_ext     = {{2{signed_op & bus.Multiplicand[WIDTH-1]}}, bus.Multiplicand};
    b_ext     = {{2{signed_op & bus.Multiplier[WIDTH-1]}}, bus.Multiplier};
    b_app     = {b_ext, 1'b0};
    a_pw      = {{(Pw - Ew){a_ext[Ew-1]}}, a_ext};
    corr_d    = '0;
    dig       = '0;
    mag       = '0;
    neg       = 1'b0;
    for (int i = 0; i < NumPp; i++) begin
      dig = b_app[2*i +: 3];
      mag = '0;
      neg = 1'b0;
      case (dig)
        3'b001, 3'b010: mag = a_pw;
        3'b011:         mag = a_pw << 1;
        3'b100: begin
          mag = a_pw << 1;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = a_pw;
          neg = 1'b1;
        end
        default: ;
      endcase
      // -X as ~X shifted in; the missing +1 lands on the digit's LSB column.
      pp_d[i]       = (neg ? ~mag : mag) << (2 * i);
      corr_d[2 * i] = neg;
    end
  end

  // S2: layered 3:2 reduction; every full group of three rows becomes two,
  // leftovers pass through, until two rows remain.
  logic [Pw-1:0] tree [NumRows];
  logic [Pw-1:0] nxt  [NumRows];
  logic [Pw-1:0] sum_d, carry_d;
  int            cnt, grp;

  always_comb begin
    for (int i = 0; i < NumPp; i++) tree[i] = s1_pp_q[i];
    tree[NumPp] = s1_corr_q;
    nxt = tree;
    cnt = NumRows;
    grp = 0;
    for (int lvl = 0; lvl < NumRows; lvl++) begin
      if (cnt > 2) begin
        grp = cnt / 3;
        for (int j = 0; j < NumRows; j++) nxt[j] = '0;
        for (int j = 0; j < NumRows / 3; j++) begin
          if (j < grp) begin
            nxt[2*j]   = tree[3*j] ^ tree[3*j+1] ^ tree[3*j+2];
            nxt[2*j+1] = ((tree[3*j] & tree[3*j+1]) | (tree[3*j] & tree[3*j+2]) |
                          (tree[3*j+1] & tree[3*j+2])) << 1;
          end
        end
        for (int j = 0; j < NumRows; j++) begin
          if (j >= 3 * grp && j < cnt) nxt[j - grp] = tree[j];
        end
        cnt  = cnt - grp;
        tree = nxt;
      end
    end
    sum_d   = tree[0];
    carry_d = tree[1];
  end

  // S3: carry-propagate add and word select (op 11 behaves as MUL).
  logic [Pw-1:0]    full_sum;
  logic [WIDTH-1:0] result_d;

  assign full_sum = s2_sum_q + s2_carry_q;

  always_comb begin
    result_d = full_sum[WIDTH-1:0];
    if (s2_op_q == 2'b01 || s2_op_q == 2'b10) result_d = full_sum[Pw-1:WIDTH];
  end

  // Control and result registers; flush beats stall and drops the incoming op.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (bus.Flush) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= bus.InValid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_data_q <= result_d;
        out_tag_q  <= s2_tag_q;
      end
    end
  end

  // Wide datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge Clk) begin
    if (adv) begin
      s1_op_q    <= bus.MulOp;
      s1_tag_q   <= bus.InTag;
      s1_pp_q    <= pp_d;
      s1_corr_q  <= corr_d;
      s2_op_q    <= s1_op_q;
      s2_tag_q   <= s1_tag_q;
      s2_sum_q   <= sum_d;
      s2_carry_q <= carry_d;
    end
  end
endmodule

// File: doc/mul_booth_pipe.md
# mul_booth_pipe

Pipelined, parametrised radix-4 Booth / Wallace-tree integer multiplier for the execute stage, covering all three multiply forms (low word, signed high word, unsigned high word). Fully pipelined: one operation issued per cycle, fixed 3-cycle latency. A result tag (destination arch register) travels with each operation. Valid/ready backpressure and a pipeline flush let it sit behind issue and in front of writeback arbitration.

## Interface
Parameters:
- WIDTH, 32, operand/result width; even, ≥ 8
- TAG_W, 5, destination-register tag width

Ports:
- Clk  in  1  clock, rising edge
- Rest  in  1  reset; asynchronous, active-low
- Flush  in  1  kill every in-flight operation
- InValid  in  1  operands present
- InReady  out  1  multiplier accepts this cycle
- MulOp  in  2  00 MUL (low word), 01 MULH (signed high), 10 MULHU (unsigned high), 11 reserved (treated as 00)
- Multiplicand  in  WIDTH  operand A
- Multiplier  in  WIDTH  operand B
- InTag  in  TAG_W  destination register
- OutValid  out  1  result valid
- OutReady  in  1  consumer takes result
- ProductData  out  WIDTH  selected result word
- OutTag  out  TAG_W  tag of result

## Operation
- Operand extension to WIDTH+2 bits: sign-extend for MUL/MULH, zero-extend for MULHU. Internal product is 2*WIDTH bits (computed WIDTH*2+4 wide, upper bits discarded).
- Stage 1 (S1): radix-4 Booth recoding of the extended Multiplier (appended 0 LSB), N = (WIDTH+2)/2 digits (17 for 32). Digits {0,±1,±2}; -X formed as ~X with +1 correction bit injected at the digit's LSB column. Partial products shifted 2*i. Register the N partial products + corrections, MulOp, tag, valid.
- Stage 2 (S2): 3:2 carry-save tree reduces all rows to two 2*WIDTH rows. Register sum, carry, MulOp, tag, valid.
- Stage 3 (S3): final carry-propagate add. Select [WIDTH-1:0] for MUL, [2*WIDTH-1:WIDTH] for MULH/MULHU. Register ProductData, OutTag, OutValid.
- Advance = ~OutValid | OutReady. When Advance=0 all three stages hold. Bubbles are not collapsed.
- InReady = Advance (combinational). Operation accepted when InValid & InReady.
- Flush: on that edge all three valid bits clear, input in the same cycle is dropped. Flush overrides stall. Data registers may keep stale values.
- Result is independent of issue order and neighbours. No state other than the pipeline registers.

## Timing
- Reset (Rest=0, asynchronous): all valids, ProductData, OutTag = 0. InReady = 1 after reset (OutValid=0).
- Latency: accepted on edge t → OutValid=1 with result after edge t+2 (3 register stages). Throughput 1/cycle while OutReady=1.
- Stall: OutValid=1 & OutReady=0 freezes S1–S3 and holds ProductData/OutTag stable. InReady=0.
- Handshake completes on the edge where OutValid & OutReady. Next stage contents shift in on that same edge.
- Reset asserted mid-operation: all in-flight results discarded immediately, no spurious OutValid after release.
- Simultaneous Flush & OutReady=0: flush wins, OutValid=0 next cycle.

## Test plan
- Basic MUL: A=3, B=0xFFFFFFFB (-5), MulOp=00 → ProductData=0xFFFFFFF1 exactly 3 cycles after accept. OutTag echoes InTag=7.
- High-word signs: MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MUL on same operands → 0x00000001. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
- Streaming: 8 back-to-back random ops with OutReady=1 → 8 consecutive OutValid cycles in order, all matching a 64-bit reference model.
- Backpressure: OutReady=0 for 4 cycles with 3 ops in flight → InReady=0, ProductData/OutTag stable. Release → ops drain in order, none lost or duplicated.
- Flush: issue 3 ops, assert Flush on cycle 2 alongside a 4th → no OutValid for any of them. An op issued the cycle after Flush appears 3 cycles later.
- Reset mid-flight plus parameter sweep: Rest low with 2 ops in pipe → outputs 0 asynchronously, no result after release. Rerun random test at WIDTH=16 and 64 against the reference model.
